alu_result_tx_sequencer: RTL
============================

Name: alu_result_tx_sequencer

Overview:
- Return-path controller for the UART ALU calculator.
- When the command parser signals a complete command (its rx_empty/done level), the block latches the 8-bit ALU result and converts it to ASCII decimal with a multi-cycle subtract loop.
- It then sequences the digits plus a terminator into the UART transmitter, using a tx_start / tx_done_tick handshake per byte.
- At the end it pulses rd to release the parser.

Parameters:
- TERM_CHAR, 8'd10: terminator byte sent after the digits (LF).
- LEAD_ZEROS, 1: 1 = always send 3 digits; 0 = suppress leading zeros, but the units digit is always sent.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- go  input  1  level request; high = command complete, result valid (connects to parser rx_empty).
- result  input  8  unsigned ALU result; sampled only on acceptance.
- tx_done_tick  input  1  one-cycle pulse from UART tx when the current byte has finished.
- tx_start  output  1  one-cycle pulse; starts transmission of din.
- din  output  8  byte presented to UART tx.
- rd  output  1  one-cycle acknowledge to the parser (connects to its rd).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; tx_start=0, din=0, rd=0, busy=0; internal remainder, digit and index registers=0.
- States: IDLE, CONVERT, LOAD, WAIT, ACK, HOLD. All outputs are registered.
- IDLE:
  - At the edge where go=1: rem<=result, hund<=0, tens<=0, units<=0, next state CONVERT.
  - go=0: remain in IDLE.
- CONVERT: one action per cycle, in priority order:
  - rem>=100: rem-=100, hund++.
  - else rem>=10: rem-=10, tens++.
  - else: units<=rem, compute the byte list, go to LOAD.
  - Cycles spent in CONVERT = hund+tens+1.
- Byte list:
  - LEAD_ZEROS=1: hund, tens, units, TERM_CHAR.
  - LEAD_ZEROS=0: hund only if hund!=0; tens only if hund!=0 or tens!=0; then units, then TERM_CHAR.
  - Digit encoding: 8'h30 + digit.
  - idx starts at the first byte to send.
- LOAD (exactly 1 cycle): tx_start=1, din=byte[idx], then go to WAIT.
  - din holds its value until the next LOAD or reset.
- WAIT:
  - tx_start=0.
  - On tx_done_tick: if idx is the last byte (TERM_CHAR), go to ACK; else idx++ and go to LOAD.
  - No timeout; WAIT may last indefinitely.
- ACK (1 cycle): rd=1, then go to HOLD.
- HOLD: rd=0; return to IDLE when go=0. This prevents a retrigger while the parser is still deasserting its level.
- Latency: the first tx_start is high in cycle hund+tens+2 after the go-sampling edge (1 cycle of latch, then CONVERT, then LOAD).
- Boundary conditions:
  - tx_done_tick is ignored in any state other than WAIT.
  - go dropping after acceptance is ignored; the sequence completes.
  - Changes on result after acceptance are ignored.
  - Max result 255 gives CONVERT = 2+5+1 = 8 cycles.
  - Result 0 gives CONVERT = 1 cycle.
- Invariants:
  - tx_start and rd are never high in the same cycle.
  - Exactly one rd pulse per accepted request.
  - Exactly one tx_start per byte.

Test Plan:
- LEAD_ZEROS=1, result=123, go held, tx_done_tick 20 cycles after each tx_start -> din sequence 0x31, 0x32, 0x33, 0x0A; 4 tx_start pulses; first tx_start in cycle 5 after acceptance; one rd pulse after the 4th tx_done_tick.
- LEAD_ZEROS=0, result=7 -> bytes 0x37, 0x0A only. LEAD_ZEROS=0, result=0 -> 0x30, 0x0A. LEAD_ZEROS=0, result=105 -> 0x31, 0x30, 0x35, 0x0A (the inner zero is kept).
- result=255 -> CONVERT lasts 8 cycles; bytes 0x32, 0x35, 0x35, 0x0A. result=0 with LEAD_ZEROS=1 -> 0x30, 0x30, 0x30, 0x0A.
- go held high for 10 cycles after rd -> FSM stays in HOLD, no second tx_start. Drop go -> IDLE next cycle, busy=0.
- Asynchronous reset during WAIT after the 2nd byte -> tx_start/rd/busy/din=0 immediately. The next go restarts from the first digit.
- Spurious tx_done_tick during IDLE, CONVERT and LOAD, and a change on result during CONVERT -> no effect on the transmitted sequence (a 42 latched gives 0x30, 0x34, 0x32, 0x0A with LEAD_ZEROS=1).

Source files
------------

// File: rtl/alu_result_tx_sequencer.sv
// Return-path sequencer: latches the ALU result, converts it to ASCII decimal
// by repeated subtraction, then feeds the digits and a terminator to the UART tx.
module alu_result_tx_sequencer #(
    parameter logic [7:0] TERM_CHAR  = 8'd10,
    parameter bit         LEAD_ZEROS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] result,
    input  logic       tx_done_tick,
    output logic       tx_start,
    output logic [7:0] din,
    output logic       rd,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, CONVERT, LOAD, WAIT, ACK, HOLD} state_t;

    state_t     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [1:0] hund_q, hund_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic [1:0] idx_q, idx_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] din_q, din_d;
    logic       rd_q, rd_d;
    logic       busy_q, busy_d;

    logic [3:0] units_now;
    logic [7:0] byte_list [4];
    logic [1:0] first_idx;

    // On the final CONVERT cycle the units digit is still in rem_q.
    always_comb begin
        units_now    = (state_q == CONVERT) ? rem_q[3:0] : units_q;
        byte_list[0] = 8'h30 + {6'd0, hund_q};
        byte_list[1] = 8'h30 + {4'd0, tens_q};
        byte_list[2] = 8'h30 + {4'd0, units_now};
        byte_list[3] = TERM_CHAR;
        if (LEAD_ZEROS || hund_q != 2'd0) first_idx = 2'd0;
        else if (tens_q != 4'd0)          first_idx = 2'd1;
        else                              first_idx = 2'd2;
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        units_d    = units_q;
        idx_d      = idx_q;
        tx_start_d = 1'b0;
        din_d      = din_q;
        rd_d       = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    rem_d   = result;
                    hund_d  = 2'd0;
                    tens_d  = 4'd0;
                    units_d = 4'd0;
                    busy_d  = 1'b1;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (rem_q >= 8'd100) begin
                    rem_d  = rem_q - 8'd100;
                    hund_d = hund_q + 2'd1;
                end else if (rem_q >= 8'd10) begin
                    rem_d  = rem_q - 8'd10;
                    tens_d = tens_q + 4'd1;
                end else begin
                    units_d    = rem_q[3:0];
                    idx_d      = first_idx;
                    tx_start_d = 1'b1;
                    din_d      = byte_list[first_idx];
                    state_d    = LOAD;
                end
            end
            LOAD: state_d = WAIT;
            WAIT: begin
                if (tx_done_tick) begin
                    if (idx_q == 2'd3) begin
                        rd_d    = 1'b1;
                        state_d = ACK;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        tx_start_d = 1'b1;
                        din_d      = byte_list[idx_q + 2'd1];
                        state_d    = LOAD;
                    end
                end
            end
            ACK: state_d = HOLD;
            HOLD: begin
                // Wait for the parser to drop its level so we don't retrigger.
                if (!go) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rem_q      <= 8'd0;
            hund_q     <= 2'd0;
            tens_q     <= 4'd0;
            units_q    <= 4'd0;
            idx_q      <= 2'd0;
            tx_start_q <= 1'b0;
            din_q      <= 8'd0;
            rd_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            hund_q     <= hund_d;
            tens_q     <= tens_d;
            units_q    <= units_d;
            idx_q      <= idx_d;
            tx_start_q <= tx_start_d;
            din_q      <= din_d;
            rd_q       <= rd_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_start = tx_start_q;
    assign din      = din_q;
    assign rd       = rd_q;
    assign busy     = busy_q;

endmodule
